// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer, the instruction ROM and the core.
package rom_fetch_sequencer_pkg;

  localparam int unsigned ROM_ADDR_WIDTH = 8;
  localparam int unsigned ROM_DATA_WIDTH = 8;

  localparam logic [7:0] DEF_RESET_ADDR  = 8'h00;
  localparam logic [7:0] DEF_IRQ0_VECTOR = 8'hFE;
  localparam logic [7:0] DEF_IRQ1_VECTOR = 8'hFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    VEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rom_fetch_sequencer_irq_priority.sv
// Fixed-priority encoder for the two interrupt lines; bit 0 wins.
module rom_fetch_sequencer_irq_priority (
  input  logic [1:0] req,
  output logic       any,
  output logic       sel,
  output logic [1:0] ack
);

  always_comb begin
    any = |req;
    sel = ~req[0] & req[1];
    ack = {sel, req[0]};
  end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Instruction-fetch controller driving a 1-cycle registered ROM; handles stall, branch and
// vectored interrupts whose handler addresses are read indirectly from ROM.
module rom_fetch_sequencer
  import rom_fetch_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ROM_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH  = ROM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = DEF_RESET_ADDR,
  parameter logic [ADDR_WIDTH-1:0] IRQ0_VECTOR = DEF_IRQ0_VECTOR,
  parameter logic [ADDR_WIDTH-1:0] IRQ1_VECTOR = DEF_IRQ1_VECTOR
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  output logic [DATA_WIDTH-1:0] INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  BRANCH_EN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
  input  logic [1:0]            IRQ_REQ,
  input  logic                  IRQ_DONE,
  output logic [1:0]            IRQ_ACK,
  output logic [ADDR_WIDTH-1:0] RET_ADDR
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  masked;
  logic                  valid;
  logic [1:0]            ack;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  irq_any;
  logic                  irq_sel;
  logic [1:0]            irq_onehot;
  logic                  handshake;
  logic                  take;

  rom_fetch_sequencer_irq_priority u_irq_priority (
    .req (IRQ_REQ),
    .any (irq_any),
    .sel (irq_sel),
    .ack (irq_onehot)
  );

  always_comb begin
    pc_inc    = pc + ADDR_WIDTH'(1);
    handshake = (state == RUN) && INSTR_READY;
    take      = handshake && !masked && irq_any;
  end

  // Next fetch address; pc follows it every edge so ROM_DATA always holds ROM[pc].
  always_comb begin
    next_addr = RESET_ADDR;
    unique case (state)
      BOOT: next_addr = RESET_ADDR;
      RUN: begin
        if (!INSTR_READY)   next_addr = pc;
        else if (take)      next_addr = irq_sel ? IRQ1_VECTOR : IRQ0_VECTOR;
        else if (BRANCH_EN) next_addr = BRANCH_ADDR;
        else                next_addr = pc_inc;
      end
      VEC:     next_addr = ADDR_WIDTH'(ROM_DATA);
      default: next_addr = RESET_ADDR;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= BOOT;
      pc       <= RESET_ADDR;
      valid    <= 1'b0;
      ack      <= 2'b00;
      ret_addr <= '0;
      masked   <= 1'b0;
    end else begin
      pc  <= next_addr;
      ack <= 2'b00;
      // A take in the same cycle as IRQ_DONE keeps interrupts masked.
      if (take)          masked <= 1'b1;
      else if (IRQ_DONE) masked <= 1'b0;
      unique case (state)
        BOOT: begin
          state <= RUN;
          valid <= 1'b1;
        end
        RUN: begin
          if (take) begin
            ret_addr <= BRANCH_EN ? BRANCH_ADDR : pc_inc;
            ack      <= irq_onehot;
            state    <= VEC;
            valid    <= 1'b0;
          end
        end
        VEC: begin
          state <= RUN;
          valid <= 1'b1;
        end
        default: begin
          state <= BOOT;
          valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ROM_ADDR    = next_addr;
    INSTR       = ROM_DATA;
    INSTR_ADDR  = pc;
    INSTR_VALID = valid;
    IRQ_ACK     = ack;
    RET_ADDR    = ret_addr;
  end

endmodule

// File: doc/rom_fetch_sequencer.md
Name: rom_fetch_sequencer

Overview:
- Instruction-fetch controller that owns the address bus of the synchronous 8-bit instruction ROM, which has a 1-cycle registered read.
- Presents one instruction per cycle to the processor core using a valid/ready handshake.
- Handles stall, branch redirect and interrupts; interrupts use indirect vectors fetched from ROM.
- Sits between the instruction ROM and the processor core's decode stage.

Parameters:
ADDR_WIDTH, 8, ROM address width.
DATA_WIDTH, 8, instruction width.
RESET_ADDR, 8'h00, first fetch address after reset.
IRQ0_VECTOR, 8'hFE, ROM location holding the IRQ0 handler start address.
IRQ1_VECTOR, 8'hFF, ROM location holding the IRQ1 handler start address.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
ROM_ADDR  out  8  address to ROM. Combinational next-PC; sampled by ROM on CLK.
ROM_DATA  in  8  ROM read data, i.e. ROM[address sampled at last edge].
INSTR  out  8  instruction to core (= ROM_DATA).
INSTR_ADDR  out  8  address of INSTR (= pc register).
INSTR_VALID  out  1  INSTR is a real instruction.
INSTR_READY  in  1  core accepts INSTR this cycle.
BRANCH_EN  in  1  redirect; only honoured when VALID&READY in the same cycle.
BRANCH_ADDR  in  8  redirect target.
IRQ_REQ  in  2  level interrupt requests; bit0 has priority.
IRQ_DONE  in  1  one-cycle pulse from core on return-from-interrupt; unmasks IRQs.
IRQ_ACK  out  2  one-cycle one-hot pulse when a vector is taken.
RET_ADDR  out  8  return address saved at interrupt entry.

Behaviour:
- Async reset: state=BOOT, pc=RESET_ADDR, INSTR_VALID=0, IRQ_ACK=0, RET_ADDR=0, masked=0. While in BOOT, ROM_ADDR=RESET_ADDR. Reset mid-operation abandons any fetch or vector with no partial state kept.
- Invariant: pc <= ROM_ADDR every edge, so ROM_DATA always equals ROM[pc] after the first edge out of BOOT.
- FSM states: BOOT, RUN, VEC.
  - BOOT: VALID=0, ROM_ADDR=RESET_ADDR, then go to RUN. The first VALID appears in the 2nd cycle after reset release.
  - RUN: VALID=1. ROM_ADDR selection, in priority order:
    1. No handshake (READY=0): ROM_ADDR=pc. The same address is re-read, so INSTR stays stable. BRANCH_EN and IRQ_REQ are ignored.
    2. Handshake, !masked, IRQ_REQ!=0: RET_ADDR <= BRANCH_EN ? BRANCH_ADDR : pc+1. ROM_ADDR=IRQ0_VECTOR if bit0 is set, else IRQ1_VECTOR. Set masked=1, go to VEC.
    3. Handshake with BRANCH_EN: ROM_ADDR=BRANCH_ADDR. Zero bubbles.
    4. Handshake otherwise: ROM_ADDR=pc+1, mod 256, so 8'hFF wraps to 8'h00.
  - VEC: VALID=0, and ROM_DATA holds the handler address. ROM_ADDR=ROM_DATA, IRQ_ACK asserted (one-hot bit of the taken IRQ) for exactly this cycle, then go to RUN. Interrupt entry costs 1 bubble cycle.
- IRQ_DONE clears masked. If IRQ_DONE coincides with an IRQ take, the take wins and masked stays 1.
- IRQs are checked only at instruction boundaries (handshake in RUN), never in BOOT or VEC.
- Simultaneous IRQ_REQ=2'b11: IRQ0 is taken; IRQ1 remains pending until unmasked.
- BRANCH_EN without a handshake has no effect.
- INSTR and INSTR_ADDR are don't-care when VALID=0.
- All address arithmetic is unsigned 8-bit modulo.

Decomposition:
- Shared package/header holds: FSM state encodings (BOOT=2'd0, RUN=2'd1, VEC=2'd2), default vector addresses, and the ADDR_WIDTH/DATA_WIDTH constants shared with the ROM and the core.
- Optional sub-module irq_priority (2-input fixed-priority encoder producing vector select and one-hot ACK). The rest stays in one module.

Test Plan:
- Release reset, READY=1 held, ROM[n]=n. Expect: VALID first high in the 2nd cycle, INSTR/INSTR_ADDR = 00,01,02… one per cycle; at FF the sequence wraps to 00.
- READY low for 3 cycles while INSTR_ADDR=05. Expect: INSTR=05 held stable 3 cycles with ROM_ADDR=05, then 06 on the cycle after READY returns.
- Handshake at INSTR_ADDR=10 with BRANCH_EN=1, BRANCH_ADDR=40. Expect: next cycle INSTR_ADDR=40, VALID stays 1 (no bubble).
- ROM[FE]=80; IRQ_REQ=01 asserted, handshake at INSTR_ADDR=20. Expect: ROM_ADDR=FE, then VEC cycle with VALID=0, IRQ_ACK=01, ROM_ADDR=80; next cycle INSTR_ADDR=80; RET_ADDR=21.
- IRQ_REQ=11 while masked=0. Expect: IRQ0 taken (ACK=01). IRQ1 is not taken until IRQ_DONE pulses, then taken on the next handshake (ACK=10, ROM_ADDR=FF).
- Assert RESET during the VEC cycle. Expect: immediately VALID=0, IRQ_ACK=0, ROM_ADDR=00, masked=0; restart from BOOT.
